legal_move_server: RTL and testbench

Multi-channel, pipelined legal-move lookup for the maze. It serves up to NUM_CH requesters (Pac-Man plus ghosts) from one shared, runtime-writable legality grid, using round-robin arbitration. Each request converts a pixel position to a tile, reads that tile's 4-bit legal-move mask, and masks turns when the sprite is not tile-aligned. It sits between the sprite position/movement logic and the direction controllers.

---
 rtl/maze_pkg.sv | 32 +++
 rtl/pos_to_tile.sv | 43 ++++
 rtl/legal_move_server.sv | 152 +++++++++++++++
 tb/tb_legal_move_server.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze constants: direction bit positions, default geometry and the default legality grid.
package maze_pkg;

    localparam int DIR_L = 3;
    localparam int DIR_R = 2;
    localparam int DIR_U = 1;
    localparam int DIR_D = 0;

    localparam int DEF_ROWS     = 8;
    localparam int DEF_COLS     = 8;
    localparam int DEF_TILE     = 60;
    localparam int DEF_ORIGIN_X = 150;
    localparam int DEF_ORIGIN_Y = 34;

    // Open 8x8 field: every move is legal unless it would leave the grid.
    function automatic logic [DEF_ROWS*DEF_COLS*4-1:0] open_grid();
        logic [DEF_ROWS*DEF_COLS*4-1:0] g;
        g = '0;
        for (int r = 0; r < DEF_ROWS; r++) begin
            for (int c = 0; c < DEF_COLS; c++) begin
                g[(r*DEF_COLS+c)*4 + DIR_L] = (c > 0);
                g[(r*DEF_COLS+c)*4 + DIR_R] = (c < DEF_COLS - 1);
                g[(r*DEF_COLS+c)*4 + DIR_U] = (r > 0);
                g[(r*DEF_COLS+c)*4 + DIR_D] = (r < DEF_ROWS - 1);
            end
        end
        return g;
    endfunction

    localparam logic [DEF_ROWS*DEF_COLS*4-1:0] GRID_DEFAULT = open_grid();

endpackage

// File: rtl/pos_to_tile.sv
// Pixel position to tile index, with bounds check and tile-alignment flags.
module pos_to_tile
    import maze_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int POS_W    = 10,
    parameter int TILE     = DEF_TILE,
    parameter int ORIGIN_X = DEF_ORIGIN_X,
    parameter int ORIGIN_Y = DEF_ORIGIN_Y
) (
    input  logic [POS_W-1:0]         i_x,
    input  logic [POS_W-1:0]         i_y,
    output logic [$clog2(ROWS)-1:0]  o_row,
    output logic [$clog2(COLS)-1:0]  o_col,
    output logic                     o_oob,
    output logic                     o_ax,
    output logic                     o_ay
);

    localparam logic [POS_W:0]   OX = (POS_W+1)'(ORIGIN_X);
    localparam logic [POS_W:0]   OY = (POS_W+1)'(ORIGIN_Y);
    localparam logic [POS_W-1:0] TW = POS_W'(TILE);

    logic [POS_W:0]   w_dx, w_dy;
    logic [POS_W-1:0] w_qx, w_qy, w_mx, w_my;

    // MSB of the widened difference is the sign: set when left of / above the grid.
    assign w_dx = {1'b0, i_x} - OX;
    assign w_dy = {1'b0, i_y} - OY;

    assign w_qx = w_dx[POS_W-1:0] / TW;
    assign w_qy = w_dy[POS_W-1:0] / TW;
    assign w_mx = w_dx[POS_W-1:0] % TW;
    assign w_my = w_dy[POS_W-1:0] % TW;

    assign o_oob = w_dx[POS_W] | w_dy[POS_W] | (32'(w_qx) >= COLS) | (32'(w_qy) >= ROWS);
    assign o_col = w_qx[$clog2(COLS)-1:0];
    assign o_row = w_qy[$clog2(ROWS)-1:0];
    assign o_ax  = (w_mx == '0);
    assign o_ay  = (w_my == '0);

endmodule

// File: rtl/legal_move_server.sv
// Round-robin, two-stage legal-move lookup against a runtime-writable grid.
module legal_move_server
    import maze_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int NUM_CH   = 4,
    parameter int POS_W    = 10,
    parameter int TILE     = DEF_TILE,
    parameter int ORIGIN_X = DEF_ORIGIN_X,
    parameter int ORIGIN_Y = DEF_ORIGIN_Y,
    parameter logic [ROWS*COLS*4-1:0] GRID_INIT = GRID_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH*POS_W-1:0]    req_x,
    input  logic [NUM_CH*POS_W-1:0]    req_y,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_CH)-1:0]  rsp_ch,
    output logic [3:0]                 rsp_moves,
    output logic [$clog2(ROWS)-1:0]    rsp_row,
    output logic [$clog2(COLS)-1:0]    rsp_col,
    output logic                       rsp_oob,
    input  logic                       wr_en,
    input  logic [$clog2(ROWS)-1:0]    wr_row,
    input  logic [$clog2(COLS)-1:0]    wr_col,
    input  logic [3:0]                 wr_moves
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic [CH_W-1:0]   r_ptr;
    logic [3:0]        r_grid [ROWS][COLS];

    logic              r_s1_valid, r_s1_oob, r_s1_ax, r_s1_ay;
    logic [CH_W-1:0]   r_s1_ch;
    logic [ROW_W-1:0]  r_s1_row;
    logic [COL_W-1:0]  r_s1_col;

    logic              w_any;
    logic [CH_W-1:0]   w_gnt_ch;
    logic [NUM_CH-1:0] w_grant;
    logic [POS_W-1:0]  w_x, w_y;
    logic [ROW_W-1:0]  w_row;
    logic [COL_W-1:0]  w_col;
    logic              w_oob, w_ax, w_ay;
    logic [3:0]        w_moves;

    // First requester at or after the pointer wins; nothing is granted while in reset.
    always_comb begin
        w_any    = 1'b0;
        w_gnt_ch = '0;
        w_grant  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_any && rst_n && req_valid[(int'(r_ptr) + k) % NUM_CH]) begin
                w_any    = 1'b1;
                w_gnt_ch = CH_W'((int'(r_ptr) + k) % NUM_CH);
            end
        end
        w_grant[w_gnt_ch] = w_any;
    end

    assign req_ready = w_grant;
    assign w_x       = req_x[w_gnt_ch*POS_W +: POS_W];
    assign w_y       = req_y[w_gnt_ch*POS_W +: POS_W];

    pos_to_tile #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .POS_W    (POS_W),
        .TILE     (TILE),
        .ORIGIN_X (ORIGIN_X),
        .ORIGIN_Y (ORIGIN_Y)
    ) u_pos_to_tile (
        .i_x   (w_x),
        .i_y   (w_y),
        .o_row (w_row),
        .o_col (w_col),
        .o_oob (w_oob),
        .o_ax  (w_ax),
        .o_ay  (w_ay)
    );

    always_comb begin
        w_moves = r_grid[r_s1_row][r_s1_col];
        if (!r_s1_ax) begin
            w_moves[DIR_U] = 1'b0;
            w_moves[DIR_D] = 1'b0;
        end
        if (!r_s1_ay) begin
            w_moves[DIR_L] = 1'b0;
            w_moves[DIR_R] = 1'b0;
        end
        if (r_s1_oob) w_moves = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_row   <= '0;
            r_s1_col   <= '0;
            r_s1_oob   <= 1'b0;
            r_s1_ax    <= 1'b0;
            r_s1_ay    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_ch     <= '0;
            rsp_moves  <= 4'b0000;
            rsp_row    <= '0;
            rsp_col    <= '0;
            rsp_oob    <= 1'b0;
        end else begin
            if (w_any) r_ptr <= (w_gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_ch + 1'b1;
            r_s1_valid <= w_any;
            if (w_any) begin
                r_s1_ch  <= w_gnt_ch;
                r_s1_row <= w_row;
                r_s1_col <= w_col;
                r_s1_oob <= w_oob;
                r_s1_ax  <= w_ax;
                r_s1_ay  <= w_ay;
            end
            rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                rsp_ch    <= r_s1_ch;
                rsp_moves <= w_moves;
                rsp_row   <= r_s1_oob ? '0 : r_s1_row;
                rsp_col   <= r_s1_oob ? '0 : r_s1_col;
                rsp_oob   <= r_s1_oob;
            end
        end
    end

    // Stage 2 reads the pre-edge contents, so a same-cycle write is seen one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_grid[r][c] <= GRID_INIT[(r*COLS+c)*4 +: 4];
                end
            end
        end else if (wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS)) begin
            r_grid[wr_row][wr_col] <= wr_moves;
        end
    end

endmodule

// File: tb/tb_legal_move_server.sv
// Directed bench for legal_move_server: lookup table, round-robin, write collision, reset.
module tb_legal_move_server;

    localparam int NUM_CH = 4;
    localparam int POS_W  = 10;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       req_valid;
    logic [NUM_CH-1:0]       req_ready;
    logic [NUM_CH*POS_W-1:0] req_x, req_y;
    logic                    rsp_valid;
    logic [1:0]              rsp_ch;
    logic [3:0]              rsp_moves;
    logic [2:0]              rsp_row, rsp_col;
    logic                    rsp_oob;
    logic                    wr_en;
    logic [2:0]              wr_row, wr_col;
    logic [3:0]              wr_moves;

    legal_move_server #(
        .NUM_CH (NUM_CH),
        .POS_W  (POS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ch    (rsp_ch),
        .rsp_moves (rsp_moves),
        .rsp_row   (rsp_row),
        .rsp_col   (rsp_col),
        .rsp_oob   (rsp_oob),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_moves  (wr_moves)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         ch;
        int         x;
        int         y;
        logic [3:0] moves;
        int         row;
        int         col;
        logic       oob;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int ch, input int x, input int y);
        req_x[ch*POS_W +: POS_W] = POS_W'(x);
        req_y[ch*POS_W +: POS_W] = POS_W'(y);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic write_cell(input int r, input int c, input logic [3:0] m);
        wr_en = 1'b1;
        wr_row = 3'(r);
        wr_col = 3'(c);
        wr_moves = m;
        step();
        wr_en = 1'b0;
    endtask

    // Single request on one channel; returns in the cycle its response is due.
    task automatic do_req(input int ch, input int x, input int y);
        req_valid = '0;
        req_valid[ch] = 1'b1;
        set_pos(ch, x, y);
        #1;
        chk("grant", 32'(req_ready), 32'(1 << ch));
        step();
        req_valid = '0;
        #1;
        chk("no_early_rsp", 32'(rsp_valid), 32'd0);
        step();
    endtask

    initial begin
        int seq_all[6];
        int seq_odd[4];
        rst_n = 1'b0;
        req_valid = '1;
        req_x = '0;
        req_y = '0;
        wr_en = 1'b0;
        wr_row = '0;
        wr_col = '0;
        wr_moves = '0;
        step();
        step();
        chk("ready_in_reset", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ch", 32'(rsp_ch), 32'd0);
        chk("rst_moves", 32'(rsp_moves), 32'd0);
        chk("rst_row", 32'(rsp_row), 32'd0);
        chk("rst_col", 32'(rsp_col), 32'd0);
        chk("rst_oob", 32'(rsp_oob), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;
        step();

        vecs[0] = '{0, 330, 154, 4'b1010, 2, 3, 1'b0};
        vecs[1] = '{1, 340, 154, 4'b1000, 2, 3, 1'b0};
        vecs[2] = '{2, 330, 160, 4'b0010, 2, 3, 1'b0};
        vecs[3] = '{3, 100, 154, 4'b0000, 0, 0, 1'b1};
        vecs[4] = '{0, 630,  34, 4'b0000, 0, 0, 1'b1};
        vecs[5] = '{1, 150,  34, 4'b0101, 0, 0, 1'b0};
        vecs[6] = '{2, 570, 454, 4'b1010, 7, 7, 1'b0};
        vecs[7] = '{3, 150,  33, 4'b0000, 0, 0, 1'b1};
        vecs[8] = '{0, 629,  34, 4'b1000, 0, 7, 1'b0};
        vecs[9] = '{1, 210, 514, 4'b0000, 0, 0, 1'b1};

        write_cell(2, 3, 4'b1010);
        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].ch, vecs[i].x, vecs[i].y);
            chk("vec_valid", 32'(rsp_valid), 32'd1);
            chk("vec_ch", 32'(rsp_ch), 32'(vecs[i].ch));
            chk("vec_moves", 32'(rsp_moves), 32'(vecs[i].moves));
            chk("vec_row", 32'(rsp_row), 32'(vecs[i].row));
            chk("vec_col", 32'(rsp_col), 32'(vecs[i].col));
            chk("vec_oob", 32'(rsp_oob), 32'(vecs[i].oob));
        end

        // Round-robin with every channel requesting.
        do_reset();
        seq_all = '{0, 1, 2, 3, 0, 1};
        for (int c = 0; c < NUM_CH; c++) set_pos(c, 150, 34);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) req_valid = '0;
            #1;
            if (k < 6) chk("rr_all_grant", 32'(req_ready), 32'(1 << seq_all[k]));
            if (k >= 2) begin
                chk("rr_all_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rr_all_rsp_ch", 32'(rsp_ch), 32'(seq_all[k-2]));
            end
            step();
        end

        // Round-robin with only channels 1 and 3.
        do_reset();
        seq_odd = '{1, 3, 1, 3};
        req_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) req_valid = '0;
            #1;
            if (k < 4) chk("rr_odd_grant", 32'(req_ready), 32'(1 << seq_odd[k]));
            if (k >= 2) chk("rr_odd_rsp_ch", 32'(rsp_ch), 32'(seq_odd[k-2]));
            step();
        end

        // Write landing in the same cycle as the stage-2 read of that cell.
        do_reset();
        write_cell(0, 0, 4'b0001);
        set_pos(0, 150, 34);
        set_pos(1, 150, 34);
        req_valid = 4'b0001;
        #1;
        chk("col_grant0", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0010;
        wr_en = 1'b1;
        wr_row = 3'd0;
        wr_col = 3'd0;
        wr_moves = 4'b1111;
        #1;
        chk("col_grant1", 32'(req_ready), 32'h2);
        step();
        wr_en = 1'b0;
        req_valid = '0;
        #1;
        chk("col_old_valid", 32'(rsp_valid), 32'd1);
        chk("col_old_ch", 32'(rsp_ch), 32'd0);
        chk("col_old_moves", 32'(rsp_moves), 32'b0001);
        step();
        chk("col_new_ch", 32'(rsp_ch), 32'd1);
        chk("col_new_moves", 32'(rsp_moves), 32'b1111);

        // Reset while a request is in flight.
        step();
        set_pos(2, 150, 34);
        req_valid = 4'b0100;
        #1;
        chk("mid_grant", 32'(req_ready), 32'h4);
        step();
        rst_n = 1'b0;
        req_valid = '1;
        #1;
        chk("mid_ready_in_reset", 32'(req_ready), 32'd0);
        step();
        req_valid = '0;
        step();
        rst_n = 1'b1;
        #1;
        chk("mid_valid", 32'(rsp_valid), 32'd0);
        chk("mid_ch", 32'(rsp_ch), 32'd0);
        chk("mid_moves", 32'(rsp_moves), 32'd0);
        chk("mid_row", 32'(rsp_row), 32'd0);
        chk("mid_col", 32'(rsp_col), 32'd0);
        chk("mid_oob", 32'(rsp_oob), 32'd0);
        for (int c = 0; c < NUM_CH; c++) set_pos(c, 150, 34);
        req_valid = '1;
        #1;
        chk("mid_ptr_zero", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        #1;
        chk("mid_no_stale_rsp", 32'(rsp_valid), 32'd0);
        step();
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mid_rsp_ch", 32'(rsp_ch), 32'd0);
        chk("mid_grid_restored", 32'(rsp_moves), 32'b0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
